d_latch_shift_register: RTL and testbench

- 8-stage shift chain of level-sensitive gated D latches.
- Serial input `sin` feeds stage 0; each stage feeds the next.
- All stage outputs are exposed in parallel on `Result`, and the last stage drives `sout`.
- All latches share one enable (`clk`). While `clk` is high the whole chain is transparent, so every stage follows `sin`. While `clk` is low the chain holds.
- Used as a teaching/reference block showing why latch chains do not shift.

---
 rtl/d_latch_shift_register.sv | 73 +++++++
 tb/tb_d_latch_shift_register.sv | 128 ++++++++++++
 2 files changed

// File: rtl/d_latch_shift_register.sv
// d_latch_shift_register
//
// A chain of WIDTH gated D latches that share a single enable. It looks like
// a shift register, but it does not shift. While the enable is high, every
// latch is transparent and the serial input ripples straight through to the
// last stage. While the enable is low, the whole chain freezes. This block is
// kept as a reference for showing why a latch chain cannot replace a
// flip-flop chain.
//
// Ports:
//   clk     in   1      shared latch enable: 1 = transparent, 0 = hold
//   reset   in   1      active-low reset, honoured only while clk is high
//   sin     in   1      serial data into stage 0
//   Result  out  WIDTH  parallel stage outputs (bit 0 = stage 0)
//   sout    out  1      serial output, a wire copy of the last stage

`timescale 1ns/1ps

// Single gated D latch with an enable-qualified active-low reset.
// Ports:
//   en     in  1  latch enable (transparent when high)
//   reset  in  1  active-low clear, effective only while en is high
//   d      in  1  data input
//   q      out 1  latched output
module d_latch (
  input  logic en,
  input  logic reset,
  input  logic d,
  output logic q
);

  // The reset sits inside the enable test. A low reset with the enable low
  // therefore leaves the stored value alone. The clear takes effect only at
  // the next transparent window.
  always_latch begin
    if (en) begin
      if (!reset) q <= 1'b0;
      else        q <= d;
    end
  end

endmodule

module d_latch_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  output logic [WIDTH-1:0] Result,
  output logic             sout
);

  // D input of each stage: stage 0 takes the serial input, and every later
  // stage takes the output of the stage before it.
  logic [WIDTH-1:0] stage_d;

  assign stage_d = {Result[WIDTH-2:0], sin};

  // All stages share clk as their enable. That shared enable is the reason
  // the chain collapses to "every bit equals sin" when transparent.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    d_latch u_latch (
      .en    (clk),
      .reset (reset),
      .d     (stage_d[i]),
      .q     (Result[i])
    );
  end

  assign sout = Result[WIDTH-1];

endmodule

// File: tb/tb_d_latch_shift_register.sv
`timescale 1ns/1ps

module tb_d_latch_shift_register;

   logic       clk;
   logic       reset;
   logic       sin;
   logic [7:0] Result;
   logic       sout;

   logic       clk4;
   logic       reset4;
   logic       sin4;
   logic [3:0] result4;
   logic       sout4;

   int testsRun;
   int testsFailed;

   d_latch_shift_register #(.WIDTH(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .sin    (sin),
      .Result (Result),
      .sout   (sout)
   );

   d_latch_shift_register #(.WIDTH(4)) dut4 (
      .clk    (clk4),
      .reset  (reset4),
      .sin    (sin4),
      .Result (result4),
      .sout   (sout4)
   );

   // Drive the 8-stage instance's enable, reset and serial input together,
   // then let the given time pass so the chain settles before any check.
   task automatic applyStimulus(input logic c, input logic r, input logic s, input int dly);
      clk   = c;
      reset = r;
      sin   = s;
      #(dly);
   endtask

   // Single comparison point: count it and report any difference.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", tag, observed, expected);
      end
   endtask

   logic sinPattern [6];

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      sinPattern  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      clk4 = 1'b0; reset4 = 1'b1; sin4 = 1'b0;

      // Reset asserted while transparent: reset must win over sin=1.
      applyStimulus(1'b1, 1'b0, 1'b1, 5);
      checkOutput("reset_early", Result, 8'h00);
      checkOutput("reset_early_sout", {7'd0, sout}, 8'h00);
      #195;
      checkOutput("reset_late", Result, 8'h00);
      checkOutput("reset_late_sout", {7'd0, sout}, 8'h00);

      // Release reset while transparent: every stage takes sin at once.
      applyStimulus(1'b1, 1'b1, 1'b1, 10);
      checkOutput("release_ff", Result, 8'hFF);
      checkOutput("release_sout", {7'd0, sout}, 8'h01);

      // Transparent tracking of sin, with no cycle latency.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, sinPattern[i], 100);
         checkOutput($sformatf("track_%0d", i), Result, sinPattern[i] ? 8'hFF : 8'h00);
         checkOutput($sformatf("track_sout_%0d", i), {7'd0, sout}, {7'd0, sinPattern[i]});
      end

      // Hold all-ones: sin toggles while clk is low must be ignored.
      applyStimulus(1'b1, 1'b1, 1'b1, 10);
      checkOutput("pre_hold_ff", Result, 8'hFF);
      applyStimulus(1'b0, 1'b1, 1'b1, 10);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, i[0], 10);
         checkOutput($sformatf("hold_ff_%0d", i), Result, 8'hFF);
         checkOutput($sformatf("hold_ff_sout_%0d", i), {7'd0, sout}, 8'h01);
      end

      // Reset while clk is low has no effect. It applies once clk rises.
      applyStimulus(1'b0, 1'b0, 1'b0, 10);
      checkOutput("reset_low_clk", Result, 8'hFF);
      applyStimulus(1'b1, 1'b0, 1'b1, 10);
      checkOutput("reset_on_rise", Result, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b1, 10);
      checkOutput("release_again", Result, 8'hFF);

      // A short sin pulse propagates immediately and returns with no latency.
      applyStimulus(1'b1, 1'b1, 1'b0, 10);
      checkOutput("pulse_base", Result, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b1, 10);
      checkOutput("pulse_high", Result, 8'hFF);
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      checkOutput("pulse_back", Result, 8'h00);

      // Hold all-zeros: raising sin while clk is low must not leak through.
      applyStimulus(1'b0, 1'b1, 1'b0, 10);
      applyStimulus(1'b0, 1'b1, 1'b1, 10);
      checkOutput("hold_00", Result, 8'h00);
      checkOutput("hold_00_sout", {7'd0, sout}, 8'h00);

      // 4-stage instance: transparent all-ones, then reset clears it.
      clk4 = 1'b1; reset4 = 1'b1; sin4 = 1'b1;
      #10;
      checkOutput("w4_ff", {4'd0, result4}, 8'h0F);
      checkOutput("w4_sout", {7'd0, sout4}, 8'h01);
      reset4 = 1'b0;
      #10;
      checkOutput("w4_reset", {4'd0, result4}, 8'h00);
      checkOutput("w4_reset_sout", {7'd0, sout4}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
